// File: rtl/i3c_reset_seq_pkg.sv
// Shared types and default constants for the I3C peripheral reset sequencer.
package i3c_reset_seq_pkg;

    localparam int unsigned DefHoldCycles = 16;
    localparam int unsigned DefAckTimeout = 256;
    localparam int unsigned DefCntWidth   = 8;

    // Wide enough for the largest legal ready-wait length.
    localparam int unsigned TmrWidth = 16;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ASSERT     = 2'd1,
        ST_WAIT_READY = 2'd2,
        ST_DONE       = 2'd3
    } state_e;

endpackage

// File: rtl/i3c_reset_sequencer_if.sv
// Request, ready and status signals between the I3C core, the sequencer and the peripheral.
interface i3c_reset_sequencer_if #(
    parameter int unsigned CntWidth = i3c_reset_seq_pkg::DefCntWidth
);
    logic                peripheral_reset_i;
    logic                escalated_reset_i;
    logic                periph_ready_i;
    logic                periph_rst_o;
    logic                peripheral_reset_done_o;
    logic                escalated_req_o;
    logic                busy_o;
    logic                timeout_o;
    logic [CntWidth-1:0] periph_rst_cnt_o;
    logic [CntWidth-1:0] escalated_cnt_o;

    // Core/peripheral side of the bundle.
    modport master (
        output peripheral_reset_i, escalated_reset_i, periph_ready_i,
        input  periph_rst_o, peripheral_reset_done_o, escalated_req_o,
        input  busy_o, timeout_o, periph_rst_cnt_o, escalated_cnt_o
    );

    // Sequencer side of the bundle.
    modport slave (
        input  peripheral_reset_i, escalated_reset_i, periph_ready_i,
        output periph_rst_o, peripheral_reset_done_o, escalated_req_o,
        output busy_o, timeout_o, periph_rst_cnt_o, escalated_cnt_o
    );
endinterface

// File: rtl/i3c_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; synchronous clear wins over increment.
module i3c_sat_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + Width'(1);
        end
    end
endmodule

// File: rtl/i3c_reset_sequencer.sv
// Turns I3C core reset requests into a timed peripheral reset, waits for the peripheral
// to report ready (bounded), and hands completion and escalation events back to the core.
module i3c_reset_sequencer
    import i3c_reset_seq_pkg::*;
#(
    parameter int unsigned HoldCycles = DefHoldCycles,
    parameter int unsigned AckTimeout = DefAckTimeout,
    parameter int unsigned CntWidth   = DefCntWidth
) (
    input logic                  clk_i,
    input logic                  rst_i,
    i3c_reset_sequencer_if.slave bus
);
    localparam logic [TmrWidth-1:0] HoldLoad = TmrWidth'(HoldCycles - 1);
    localparam logic [TmrWidth-1:0] AckLoad  = TmrWidth'(AckTimeout - 1);

    state_e                state_q, state_d;
    logic [TmrWidth-1:0]   tmr_q, tmr_d;
    logic                  seq_esc_q, seq_esc_d;
    logic                  timeout_q, timeout_d;
    logic                  per_q, esc_q, armed_q;
    logic                  per_rise, esc_rise;
    logic                  per_inc, esc_inc;
    logic                  periph_rst_q, done_q, busy_q, esc_req_q;
    logic [CntWidth-1:0]   per_cnt, esc_cnt;

    // armed_q keeps a level that is already high when reset releases from reading as an edge.
    assign per_rise = armed_q & bus.peripheral_reset_i & ~per_q;
    assign esc_rise = armed_q & bus.escalated_reset_i & ~esc_q;

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        seq_esc_d = seq_esc_q;
        timeout_d = timeout_q;
        per_inc   = 1'b0;
        esc_inc   = 1'b0;
        if (esc_rise) begin
            state_d   = ST_ASSERT;
            tmr_d     = HoldLoad;
            seq_esc_d = 1'b1;
            esc_inc   = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (per_rise) begin
                        state_d   = ST_ASSERT;
                        tmr_d     = HoldLoad;
                        seq_esc_d = 1'b0;
                    end
                end
                ST_ASSERT: begin
                    if (tmr_q == '0) begin
                        state_d = ST_WAIT_READY;
                        tmr_d   = AckLoad;
                    end else begin
                        tmr_d = tmr_q - TmrWidth'(1);
                    end
                end
                ST_WAIT_READY: begin
                    if (bus.periph_ready_i) begin
                        state_d = ST_DONE;
                        per_inc = 1'b1;
                    end else if (tmr_q == '0) begin
                        state_d   = ST_DONE;
                        timeout_d = 1'b1;
                        per_inc   = 1'b1;
                    end else begin
                        tmr_d = tmr_q - TmrWidth'(1);
                    end
                end
                ST_DONE: begin
                    // An escalated sequence also waits for its own request to drop.
                    if (!bus.peripheral_reset_i && !(seq_esc_q && bus.escalated_reset_i)) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, edge-detect and registered outputs, all derived from the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            tmr_q        <= '0;
            seq_esc_q    <= 1'b0;
            timeout_q    <= 1'b0;
            per_q        <= 1'b0;
            esc_q        <= 1'b0;
            armed_q      <= 1'b0;
            periph_rst_q <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            esc_req_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            seq_esc_q    <= seq_esc_d;
            timeout_q    <= timeout_d;
            per_q        <= bus.peripheral_reset_i;
            esc_q        <= bus.escalated_reset_i;
            armed_q      <= 1'b1;
            periph_rst_q <= (state_d == ST_ASSERT);
            done_q       <= (state_d == ST_DONE);
            busy_q       <= (state_d != ST_IDLE);
            esc_req_q    <= esc_rise;
        end
    end

    i3c_sat_counter #(.Width(CntWidth)) u_per_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (per_inc),
        .cnt_o (per_cnt)
    );

    i3c_sat_counter #(.Width(CntWidth)) u_esc_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (esc_inc),
        .cnt_o (esc_cnt)
    );

    assign bus.periph_rst_o            = periph_rst_q;
    assign bus.peripheral_reset_done_o = done_q;
    assign bus.escalated_req_o         = esc_req_q;
    assign bus.busy_o                  = busy_q;
    assign bus.timeout_o               = timeout_q;
    assign bus.periph_rst_cnt_o        = per_cnt;
    assign bus.escalated_cnt_o         = esc_cnt;
endmodule

// File: doc/i3c_reset_sequencer.md
I3C_RESET_SEQUENCER -- requirements
Module: i3c_reset_sequencer

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter HoldCycles, default 16, SHALL set the number of cycles periph_rst_o is held asserted; legal range is 1..255.
REQ-003 Parameter AckTimeout, default 256, SHALL set the maximum number of cycles spent waiting for periph_ready_i; legal range is 1..65535.
REQ-004 Parameter CntWidth, default 8, SHALL set the width of the event counters.
REQ-005 Ports (name, direction, width, meaning):
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- peripheral_reset_i  in  1  level request from I3C core (its peripheral_reset_o)
- escalated_reset_i  in  1  level request from I3C core (its escalated_reset_o)
- periph_ready_i  in  1  downstream peripheral reports out-of-reset and ready
- periph_rst_o  out  1  active-high reset driven to the downstream peripheral
- peripheral_reset_done_o  out  1  completion back to I3C core (its peripheral_reset_done_i)
- escalated_req_o  out  1  one-cycle system-reset request pulse
- busy_o  out  1  high whenever the FSM is not in IDLE
- timeout_o  out  1  sticky flag: ready wait timed out
- periph_rst_cnt_o  out  CntWidth  completed peripheral reset sequences
- escalated_cnt_o  out  CntWidth  escalated reset events

Function
REQ-006 Both request inputs SHALL be edge-detected against a registered copy; only 0->1 transitions start actions.
REQ-007 The FSM SHALL have states IDLE, ASSERT, WAIT_READY and DONE, one-hot or binary encoded.
REQ-008 A peripheral_reset_i rise sampled at edge k in IDLE SHALL move to ASSERT at k+1, with periph_rst_o=1 from k+1.
REQ-009 ASSERT SHALL hold periph_rst_o=1 for exactly HoldCycles cycles, then enter WAIT_READY with periph_rst_o=0.
REQ-010 WAIT_READY SHALL enter DONE on the first cycle periph_ready_i=1.
- Otherwise it SHALL enter DONE after AckTimeout cycles and set timeout_o.
REQ-011 DONE SHALL drive peripheral_reset_done_o=1 and increment periph_rst_cnt_o once on entry.
- DONE SHALL remain until peripheral_reset_i=0, then return to IDLE on the next cycle.
REQ-012 A peripheral_reset_i rise while not in IDLE SHALL be ignored, with no counter change.
REQ-013 An escalated_reset_i rise in any state SHALL do the following, with priority over all other transitions:
- pulse escalated_req_o for exactly one cycle;
- increment escalated_cnt_o;
- enter ASSERT with the hold counter reloaded.
REQ-014 An escalated sequence SHALL complete through WAIT_READY and DONE like a peripheral one.
- DONE SHALL exit when both request inputs are 0.
REQ-015 Simultaneous rises of both inputs SHALL be handled as escalated only; the peripheral edge is consumed.
REQ-016 Counters SHALL saturate at all-ones and never wrap.
REQ-017 All outputs SHALL be registered; there SHALL be no combinational path from input to output.

Reset
REQ-018 On rst_i the following SHALL clear to 0 on the next clock edge:
- FSM returns to IDLE;
- periph_rst_o, peripheral_reset_done_o, escalated_req_o, busy_o and timeout_o;
- both counters and the edge-detect registers.
REQ-019 rst_i asserted mid-sequence SHALL abort the sequence; periph_rst_o SHALL drop in the cycle after reset is sampled.
REQ-020 A request input already high when reset deasserts SHALL NOT be treated as an edge.

Structure
REQ-021 Package i3c_reset_seq_pkg SHALL hold the FSM state typedef and the default parameter constants.
REQ-022 Sub-module i3c_sat_counter (parameterised width, increment strobe, synchronous clear) SHALL be instantiated for both event counters.

Verification
REQ-023 Directed scenarios the bench SHALL cover:
- Nominal: HoldCycles=16, peripheral_reset_i rises, periph_ready_i rises 5 cycles after release -> periph_rst_o high 16 cycles, done_o high, periph_rst_cnt_o=1, timeout_o=0.
- Timeout: AckTimeout=256, periph_ready_i held 0 -> DONE entered 256 cycles after release, timeout_o=1 sticky, done_o=1.
- Escalation mid-WAIT_READY: escalated_reset_i rises -> escalated_req_o 1-cycle pulse, escalated_cnt_o=1, periph_rst_o re-asserted for 16 cycles.
- Simultaneous rises of both inputs -> periph_rst_o asserted, escalated_cnt_o=1, then periph_rst_cnt_o=1 after completion.
- Saturation: CntWidth=2, 5 sequences -> periph_rst_cnt_o=3.
- Reset mid-ASSERT with peripheral_reset_i held high -> all outputs 0, busy_o=0, no restart until a new rise of peripheral_reset_i.
